scalar_to_axi_stream: RTL and testbench
=======================================

Name: scalar_to_axi_stream

Overview:
Transmit-side counterpart of the stream-to-scalar receiver: takes a free-running scalar sample flow (data_in/data_valid, no backpressure) from filter outputs and presents it as an AXI4-Stream master with tlast framing. Sits between processing blocks (FIR/CIC/Sobel datapaths) and a DMA or stream interconnect. Absorbs downstream tready stalls in a FIFO. Reports dropped samples through a sticky overflow flag.

Parameters:
DATA_WIDTH, 16, width of data_in and tdata.
DEPTH, 16, FIFO array entries; power of 2, >= 2.
FRAME_LEN, 256, beats per frame; tlast is asserted on the last beat of each frame; >= 1.

Ports:
clk  in  1  single clock; all logic on its rising edge.
resetn  in  1  asynchronous, active-low reset.
data_in  in  DATA_WIDTH  scalar sample.
data_valid  in  1  data_in is valid this cycle; the producer does not wait.
clr_overflow  in  1  synchronous clear of the overflow flag.
tdata  out  DATA_WIDTH  stream data.
tvalid  out  1  stream valid.
tready  in  1  downstream ready.
tlast  out  1  last beat of a frame.
level  out  clog2(DEPTH+2)  samples held: FIFO entries plus 1 if the output register is full.
overflow  out  1  sticky; set when a sample was dropped.

Behaviour:
- Reset (resetn low, asynchronous): tvalid=0, tlast=0, tdata=0, level=0, overflow=0. FIFO pointers and beat counter are zeroed. Reset mid-frame discards all contents.
- Storage consists of a DEPTH-entry FIFO array feeding one output register that drives tdata/tvalid/tlast. Total capacity is DEPTH+1.
- pop = tvalid && tready. The output register is refilled on the same edge as pop, from the FIFO head if the FIFO is non-empty. If the FIFO is empty and data_valid is high, it is refilled directly from data_in (bypass).
- Latency: if the block is empty, a sample with data_valid high at edge k is on tdata with tvalid=1 immediately after edge k.
- Accept rule: data_valid is accepted if level < DEPTH+1, or if pop occurs on the same edge. Otherwise the sample is dropped and overflow is set on that edge.
- Simultaneous push and pop when full: accepted, and level is unchanged.
- Priority on the same edge as clr_overflow:
  - If a drop occurs on that edge, overflow remains 1 (set wins).
  - Otherwise overflow becomes 0.
- AXI rules:
  - Once tvalid is 1, tdata and tlast stay constant until pop.
  - tvalid never depends combinationally on tready.
  - tvalid goes to 0 only after a pop that leaves no data available.
- Framing:
  - The beat counter (0..FRAME_LEN-1) increments on each pop.
  - It wraps to 0 on the pop of the beat where tlast=1.
  - tlast=1 when the beat currently presented is the counter value FRAME_LEN-1.
  - tlast is computed when the output register loads and is held with the data.
  - If FRAME_LEN=1, every beat has tlast=1.
- Dropped samples do not advance the beat counter, so frames stay contiguous in accepted-sample count.
- level updates registered: +1 on accepted push without pop, -1 on pop without push.
- FIFO pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

Test Plan:
- Latency: empty block, tready=1, single data_valid with data_in=0x1234 -> tvalid=1, tdata=0x1234 in the cycle after the edge; popped next edge; tvalid=0; level returns 0.
- Framing: FRAME_LEN=4, tready=1, 10 consecutive samples 1..10 -> tlast=1 on beats 4 and 8 only; beats 9 and 10 have tlast=0; counter=2 at the end.
- Backpressure: tready=0, 18 samples 0x100..0x111 -> level=17, the 18th sample is dropped, overflow=1. Then set tready=1 -> output 0x100..0x110 in order with no gaps.
- Full with simultaneous pop: fill to 17, then tready=1 together with data_valid each cycle for 5 cycles -> no drops, overflow stays 0, level stays 17.
- Overflow clear: overflow=1, pulse clr_overflow with no drop -> overflow=0. Then pulse clr_overflow coincident with a drop -> overflow stays 1.
- Reset mid-frame: FRAME_LEN=4, 2 beats popped and 5 samples queued, assert resetn=0 asynchronously mid-cycle -> tvalid, level and tlast become 0 at once. After release, the next 4 samples end with tlast on the 4th beat.

Source files
------------

// File: rtl/scalar_to_axi_stream.sv
// scalar_to_axi_stream
//   Turns a free-running scalar sample flow (no backpressure) into an
//   AXI4-Stream master with tlast framing. A DEPTH-entry FIFO feeds one
//   output register, so the block holds up to DEPTH+1 samples. A sample that
//   arrives while the block is full is dropped, and that sets a sticky
//   overflow flag.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   data_in      scalar sample
//   data_valid   data_in valid this cycle (the producer never waits)
//   clr_overflow synchronous clear of overflow; a drop on the same edge wins
//   tdata        stream data
//   tvalid       stream valid
//   tready       downstream ready
//   tlast        last beat of a FRAME_LEN-beat frame
//   level        samples held (FIFO entries + output register)
//   overflow     sticky drop indicator
module scalar_to_axi_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        data_valid,
  input  logic                        clr_overflow,
  output logic [DATA_WIDTH-1:0]       tdata,
  output logic                        tvalid,
  input  logic                        tready,
  output logic                        tlast,
  output logic [$clog2(DEPTH+2)-1:0]  level,
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+2);
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [LW-1:0]         r_level;
  logic                  r_overflow;
  // Frame index of the beat that sits (or will next sit) in the output register.
  logic [CW-1:0]         r_beat_cnt;

  logic          w_fifo_empty;
  logic          w_pop;
  logic          w_out_free;
  logic          w_accept;
  logic          w_drop;
  logic          w_bypass;
  logic          w_fifo_wr;
  logic          w_fifo_rd;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_load_idx;
  logic          w_load_last;

  always_comb begin
    w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    w_pop        = r_out_valid && tready;
    w_out_free   = !r_out_valid || w_pop;
    w_accept     = data_valid && ((r_level < LW'(DEPTH+1)) || w_pop);
    w_drop       = data_valid && !w_accept;
    w_bypass     = w_out_free && w_fifo_empty && data_valid;
    w_fifo_rd    = w_out_free && !w_fifo_empty;
    w_fifo_wr    = w_accept && !w_bypass;
    w_cnt_inc    = (r_beat_cnt == CW'(FRAME_LEN-1)) ? '0 : r_beat_cnt + CW'(1);
    // A load that coincides with a pop presents the following beat, so its
    // frame position is the post-pop counter value.
    w_load_idx   = w_pop ? w_cnt_inc : r_beat_cnt;
    w_load_last  = (w_load_idx == CW'(FRAME_LEN-1));
  end

  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_fifo_rd) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end

      if (w_out_free) begin
        if (w_fifo_rd) begin
          r_out_data  <= r_mem[r_rd_ptr[AW-1:0]];
          r_out_valid <= 1'b1;
          r_out_last  <= w_load_last;
        end else if (w_bypass) begin
          r_out_data  <= data_in;
          r_out_valid <= 1'b1;
          r_out_last  <= w_load_last;
        end else begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end

      if (w_pop) begin
        r_beat_cnt <= w_cnt_inc;
      end

      if (w_accept && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_accept) begin
        r_level <= r_level - LW'(1);
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign tdata    = r_out_data;
  assign tvalid   = r_out_valid;
  assign tlast    = r_out_last;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_scalar_to_axi_stream.sv
module tb_scalar_to_axi_stream;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int FLEN  = 4;
  localparam int CAP   = DEPTH + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic [4:0]    level;
  logic          overflow;

  scalar_to_axi_stream #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .FRAME_LEN  (FLEN)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .clr_overflow (clr_overflow),
    .tdata        (tdata),
    .tvalid       (tvalid),
    .tready       (tready),
    .tlast        (tlast),
    .level        (level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Bench reference model
  int m_level = 0;
  int m_cnt   = 0;
  bit m_ovf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard side: a beat is consumed on the next rising edge whenever
  // tvalid && tready are both high at the falling edge.
  always @(negedge clk) begin
    if (resetn && tvalid && tready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 32'(tdata), 32'hDEAD_BEEF);
      end else begin
        beat_t b;
        b = sb_q.pop_front();
        check("tdata", 32'(tdata), 32'(b.data));
        check("tlast", 32'(tlast), 32'(b.last));
      end
    end
  end

  task automatic model_clear();
    sb_q.delete();
    m_level = 0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    data_valid = 1'b0; clr_overflow = 1'b0; tready = 1'b0;
    model_clear();
    #2;
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_level", 32'(level), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit dv, input logic [DW-1:0] din, input bit rdy, input bit clr);
    bit pop, acc;
    data_valid = dv; data_in = din; tready = rdy; clr_overflow = clr;
    @(posedge clk);
    pop = (m_level > 0) && rdy;
    acc = dv && ((m_level < CAP) || pop);
    if (acc) begin
      sb_q.push_back({din, (m_cnt == FLEN-1)});
      m_cnt = (m_cnt + 1) % FLEN;
    end
    m_level = m_level + int'(acc) - int'(pop);
    if (dv && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    #1;
    data_valid = 1'b0; clr_overflow = 1'b0;
    check("level", 32'(level), 32'(m_level));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tvalid", 32'(tvalid), 32'(m_level > 0));
  endtask

  task automatic drain();
    for (int i = 0; i < 2*CAP && m_level > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("drained_level", 32'(level), 0);
    check("sb_empty", 32'(sb_q.size()), 0);
  endtask

  initial begin
    // Reset values
    #3;
    check("reset_tvalid", 32'(tvalid), 0);
    check("reset_tlast", 32'(tlast), 0);
    check("reset_tdata", 32'(tdata), 0);
    check("reset_level", 32'(level), 0);
    check("reset_overflow", 32'(overflow), 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Latency: bypass into the output register on the same edge
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    check("lat_tvalid", 32'(tvalid), 1);
    check("lat_tdata", 32'(tdata), 32'h1234);
    step(1'b0, '0, 1'b1, 1'b0);
    check("lat_empty", 32'(tvalid), 0);
    check("lat_level", 32'(level), 0);

    // Framing: 10 back-to-back beats, tlast on beats 4 and 8
    do_reset();
    for (int i = 1; i <= 10; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    drain();

    // Backpressure: 18 samples into a stalled stream; last one drops
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, DW'(16'h100 + i), 1'b0, 1'b0);
    check("bp_level", 32'(level), 17);
    check("bp_overflow", 32'(overflow), 1);
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1, 1'b0);
    drain();

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < CAP; i++) step(1'b1, DW'(16'h200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(16'h300 + i), 1'b1, 1'b0);
      check("full_pop_level", 32'(level), 17);
      check("full_pop_ovf", 32'(overflow), 0);
    end

    // Overflow clear and set-wins priority (block still full, tready low)
    step(1'b1, 16'hBAD0, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 0);
    step(1'b1, 16'hBAD1, 1'b0, 1'b0);
    step(1'b1, 16'hBAD2, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(overflow), 1);
    drain();

    // Reset mid-frame: 2 beats out, 5 queued, then asynchronous reset
    do_reset();
    step(1'b1, 16'h0A01, 1'b1, 1'b0);
    step(1'b1, 16'h0A02, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0B00 + i), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 5);
    #2;
    resetn = 1'b0;
    model_clear();
    #1;
    check("async_tvalid", 32'(tvalid), 0);
    check("async_level", 32'(level), 0);
    check("async_tlast", 32'(tlast), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h0C00 + i), 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
